// File: rtl/sliding_window_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sliding_window_pkg
//  Purpose  : Shared constants, FP16 word layout and width helper for the
//             sliding-window generator and its line buffers.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package sliding_window_pkg;

    // Column/row counters and the col_o/row_o ports are this wide.
    localparam int COORD_WIDTH    = 16;

    // Default FP16 field widths, used by the fp_word_t layout.
    localparam int FP16_EXP_WIDTH  = 5;
    localparam int FP16_FRAC_WIDTH = 10;

    // Total pixel word width for a given exponent/fraction split.
    function automatic int fp_width_f(input int exp_width, input int frac_width);
        return 1 + exp_width + frac_width;
    endfunction

    typedef struct packed {
        logic                       sign;
        logic [FP16_EXP_WIDTH-1:0]  exponent;
        logic [FP16_FRAC_WIDTH-1:0] fraction;
    } fp_word_t;

endpackage
`default_nettype wire

// File: rtl/window_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : window_line_buffer
//  Purpose  : One image line of pixel storage. Combinational read and
//             synchronous write share a single address, so a read in the
//             same cycle as a write returns the old contents.
//  Ports    : clk_i   - clock
//             we_i    - write enable
//             addr_i  - column address
//             wdata_i - pixel written at addr_i on the rising edge
//             rdata_o - pixel currently stored at addr_i
//  Revision : 1.0 - initial release
// ============================================================================
module window_line_buffer #(
    parameter int DEPTH      = 640,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o
);

    // Contents are deliberately left unreset; stale data is masked by the
    // valid gating in the window generator.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/sliding_window_gen_fp16.sv
`default_nettype none
// ============================================================================
//  Module   : sliding_window_gen_fp16
//  Purpose  : Builds a WINDOW_HEIGHT x WINDOW_WIDTH window of FP16 pixels from
//             a raster-order stream for the convolution stage. No backpressure.
//  Ports    : clk_i    - clock
//             rst_i    - synchronous active-low reset
//             data_i   - input pixel
//             valid_i  - pixel qualifier
//             sof_i    - start of frame (forces the pixel to (0,0))
//             window_o - window, [H-1][W-1] is the newest pixel
//             col_o    - column of the newest pixel
//             row_o    - row of the newest pixel
//             valid_o  - window lies fully inside the image
//  Revision : 1.0 - initial release
// ============================================================================
module sliding_window_gen_fp16
    import sliding_window_pkg::*;
#(
    parameter int  EXP_WIDTH     = 5,
    parameter int  FRAC_WIDTH    = 10,
    parameter int  WINDOW_WIDTH  = 2,
    parameter int  WINDOW_HEIGHT = 1,
    parameter int  IMAGE_WIDTH   = 640,
    parameter int  IMAGE_HEIGHT  = 480,
    localparam int FP_WIDTH_REG  = fp_width_f(EXP_WIDTH, FRAC_WIDTH)
) (
    input  logic                                                      clk_i,
    input  logic                                                      rst_i,
    input  logic [FP_WIDTH_REG-1:0]                                   data_i,
    input  logic                                                      valid_i,
    input  logic                                                      sof_i,
    output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o,
    output logic [COORD_WIDTH-1:0]                                    col_o,
    output logic [COORD_WIDTH-1:0]                                    row_o,
    output logic                                                      valid_o
);

    localparam logic [COORD_WIDTH-1:0] LAST_COL        = COORD_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] LAST_ROW        = COORD_WIDTH'(IMAGE_HEIGHT - 1);
    localparam logic [COORD_WIDTH-1:0] FIRST_VALID_COL = COORD_WIDTH'(WINDOW_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] FIRST_VALID_ROW = COORD_WIDTH'(WINDOW_HEIGHT - 1);
    localparam int LB_ADDR_WIDTH = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

    typedef logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_t;

    logic [COORD_WIDTH-1:0] cnt_col_q, cnt_col_d;
    logic [COORD_WIDTH-1:0] cnt_row_q, cnt_row_d;
    logic [COORD_WIDTH-1:0] out_col_q, out_col_d;
    logic [COORD_WIDTH-1:0] out_row_q, out_row_d;
    logic                   out_valid_q, out_valid_d;
    window_t                window_q, window_d;

    logic [COORD_WIDTH-1:0] pix_col;
    logic [COORD_WIDTH-1:0] pix_row;
    logic                   col_ok;
    logic                   row_ok;
    logic                   lb_we;
    logic [WINDOW_HEIGHT-1:0][FP_WIDTH_REG-1:0]                    col_vec;
    window_t                                                        window_shift;

    // Coordinate of the pixel being accepted this cycle.
    assign pix_col = sof_i ? '0 : cnt_col_q;
    assign pix_row = sof_i ? '0 : cnt_row_q;

    // Gating compares collapse to constant true for a 1-wide / 1-high window.
    if (WINDOW_WIDTH > 1) begin : g_col_gate
        assign col_ok = (pix_col >= FIRST_VALID_COL);
    end else begin : g_col_always
        assign col_ok = 1'b1;
    end

    if (WINDOW_HEIGHT > 1) begin : g_row_gate
        assign row_ok = (pix_row >= FIRST_VALID_ROW);
    end else begin : g_row_always
        assign row_ok = 1'b1;
    end

    // Reset takes priority over a same-cycle write.
    assign lb_we = valid_i & rst_i;

    // Column vector: newest pixel in the bottom row, line buffers above it.
    assign col_vec[WINDOW_HEIGHT-1] = data_i;

    if (WINDOW_HEIGHT > 1) begin : g_lb
        logic [WINDOW_HEIGHT-2:0][FP_WIDTH_REG-1:0] lb_rd;

        for (genvar k = 0; k < WINDOW_HEIGHT - 1; k++) begin : g_lb_row
            logic [FP_WIDTH_REG-1:0] lb_wr;

            // Buffers form a vertical chain: each one receives the line the
            // buffer below it is about to give up.
            if (k == 0) begin : g_first
                assign lb_wr = data_i;
            end else begin : g_chain
                assign lb_wr = lb_rd[k-1];
            end

            window_line_buffer #(
                .DEPTH      (IMAGE_WIDTH),
                .WIDTH      (FP_WIDTH_REG),
                .ADDR_WIDTH (LB_ADDR_WIDTH)
            ) u_line_buffer (
                .clk_i   (clk_i),
                .we_i    (lb_we),
                .addr_i  (pix_col[LB_ADDR_WIDTH-1:0]),
                .wdata_i (lb_wr),
                .rdata_o (lb_rd[k])
            );

            assign col_vec[WINDOW_HEIGHT-2-k] = lb_rd[k];
        end
    end

    // Each window row shifts left by one, taking its new column entry at the
    // newest (highest) index.
    for (genvar j = 0; j < WINDOW_HEIGHT; j++) begin : g_win_row
        if (WINDOW_WIDTH > 1) begin : g_shift
            assign window_shift[j] = {col_vec[j], window_q[j][WINDOW_WIDTH-1:1]};
        end else begin : g_single
            assign window_shift[j] = col_vec[j];
        end
    end

    always_comb begin
        cnt_col_d   = cnt_col_q;
        cnt_row_d   = cnt_row_q;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        out_valid_d = 1'b0;
        window_d    = window_q;

        if (valid_i) begin
            if (pix_col < LAST_COL) begin
                cnt_col_d = pix_col + COORD_WIDTH'(1);
                cnt_row_d = pix_row;
            end else if (pix_row < LAST_ROW) begin
                cnt_col_d = '0;
                cnt_row_d = pix_row + COORD_WIDTH'(1);
            end else begin
                cnt_col_d = '0;
                cnt_row_d = '0;
            end

            out_col_d   = pix_col;
            out_row_d   = pix_row;
            out_valid_d = col_ok & row_ok;
            window_d    = window_shift;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_col_q   <= '0;
            cnt_row_q   <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
            window_q    <= '0;
        end else begin
            cnt_col_q   <= cnt_col_d;
            cnt_row_q   <= cnt_row_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            out_valid_q <= out_valid_d;
            window_q    <= window_d;
        end
    end

    assign window_o = window_q;
    assign col_o    = out_col_q;
    assign row_o    = out_row_q;
    assign valid_o  = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sliding_window_gen_fp16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sliding_window_gen_fp16
//  Purpose  : Self-checking bench for sliding_window_gen_fp16. Instance A is a
//             2x1 window over a 4x3 image, instance B a 3x3 window over a 5x4
//             image. A reference model keeps the image by coordinate and
//             derives each expected window directly from it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sliding_window_gen_fp16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic [15:0]            din_a, din_b;
    logic                   vin_a, vin_b, sof_a, sof_b;
    logic [0:0][1:0][15:0]  win_a;
    logic [2:0][2:0][15:0]  win_b;
    logic [15:0]            col_a, row_a, col_b, row_b;
    logic                   vout_a, vout_b;

    sliding_window_gen_fp16 #(
        .EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_WIDTH(2), .WINDOW_HEIGHT(1),
        .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3)
    ) dut_a (
        .clk_i(clk), .rst_i(rst_n), .data_i(din_a), .valid_i(vin_a), .sof_i(sof_a),
        .window_o(win_a), .col_o(col_a), .row_o(row_a), .valid_o(vout_a)
    );

    sliding_window_gen_fp16 #(
        .EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_WIDTH(3), .WINDOW_HEIGHT(3),
        .IMAGE_WIDTH(5), .IMAGE_HEIGHT(4)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_n), .data_i(din_b), .valid_i(vin_b), .sof_i(sof_b),
        .window_o(win_b), .col_o(col_b), .row_o(row_b), .valid_o(vout_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state, per instance (0 = A, 1 = B)
    int mc [2];
    int mr [2];
    int ecol [2];
    int erow [2];
    int img [2][4][5];
    int seen_valid [2];

    function automatic int win_w(int s);  return (s == 0) ? 2 : 3; endfunction
    function automatic int win_h(int s);  return (s == 0) ? 1 : 3; endfunction
    function automatic int img_w(int s);  return (s == 0) ? 4 : 5; endfunction
    function automatic int img_h(int s);  return (s == 0) ? 3 : 4; endfunction

    function automatic logic [15:0] get_win(int s, int j, int i);
        if (s == 0) return win_a[0][i[0]];
        else        return win_b[j[1:0]][i[1:0]];
    endfunction
    function automatic logic get_valid(int s); return (s == 0) ? vout_a : vout_b; endfunction
    function automatic logic [15:0] get_col(int s); return (s == 0) ? col_a : col_b; endfunction
    function automatic logic [15:0] get_row(int s); return (s == 0) ? row_a : row_b; endfunction

    // Exact FP16 encoding of a small non-negative integer.
    function automatic logic [15:0] to_fp16(int v);
        int e;
        int frac;
        if (v == 0) return 16'h0000;
        e = 0;
        for (int b = 0; b < 12; b++) if (((v >> b) & 1) == 1) e = b;
        frac = (v << (10 - e)) & 'h3FF;
        return {1'b0, 5'(e + 15), 10'(frac)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_img(int s);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++)
                img[s][r][c] = -1;
    endtask

    // One clock cycle on instance s. rst_act=1 holds rst_i low for the cycle.
    task automatic cycle(int s, bit rst_act, bit v, bit sf, logic [15:0] d);
        int  pc, pr;
        bit  exp_valid;
        string nm;
        rst_n = ~rst_act;
        vin_a = (s == 0) && v;  sof_a = (s == 0) && sf;  din_a = d;
        vin_b = (s == 1) && v;  sof_b = (s == 1) && sf;  din_b = d;
        @(posedge clk);
        #1;
        if (rst_act) begin
            for (int k = 0; k < 2; k++) begin
                nm = (k == 0) ? "a" : "b";
                mc[k] = 0; mr[k] = 0; ecol[k] = 0; erow[k] = 0;
                clear_img(k);
                check({nm, " reset valid"}, 32'(get_valid(k)), 32'd0);
                check({nm, " reset col"},   32'(get_col(k)),   32'd0);
                check({nm, " reset row"},   32'(get_row(k)),   32'd0);
                for (int j = 0; j < win_h(k); j++)
                    for (int i = 0; i < win_w(k); i++)
                        check($sformatf("%s reset win[%0d][%0d]", nm, j, i),
                              32'(get_win(k, j, i)), 32'd0);
            end
        end else begin
            nm = (s == 0) ? "a" : "b";
            exp_valid = 1'b0;
            pc = 0; pr = 0;
            if (v) begin
                pc = sf ? 0 : mc[s];
                pr = sf ? 0 : mr[s];
                if (pc == 0 && pr == 0) clear_img(s);
                img[s][pr][pc] = int'(d);
                exp_valid = (pc >= win_w(s) - 1) && (pr >= win_h(s) - 1);
                ecol[s] = pc;
                erow[s] = pr;
                if (pc < img_w(s) - 1) begin
                    mc[s] = pc + 1; mr[s] = pr;
                end else if (pr < img_h(s) - 1) begin
                    mc[s] = 0; mr[s] = pr + 1;
                end else begin
                    mc[s] = 0; mr[s] = 0;
                end
            end
            check({nm, " valid"}, 32'(get_valid(s)), 32'(exp_valid));
            check({nm, " col"},   32'(get_col(s)),   32'(ecol[s]));
            check({nm, " row"},   32'(get_row(s)),   32'(erow[s]));
            if (get_valid(s)) seen_valid[s]++;
            if (exp_valid) begin
                for (int j = 0; j < win_h(s); j++)
                    for (int i = 0; i < win_w(s); i++)
                        check($sformatf("%s win[%0d][%0d] @(%0d,%0d)", nm, j, i, pc, pr),
                              32'(get_win(s, j, i)),
                              32'(img[s][pr - (win_h(s) - 1 - j)][pc - (win_w(s) - 1 - i)]));
            end
        end
    endtask

    initial begin
        int acc;
        rst_n = 1'b0;
        vin_a = 1'b0; sof_a = 1'b0; din_a = '0;
        vin_b = 1'b0; sof_b = 1'b0; din_b = '0;
        seen_valid[0] = 0; seen_valid[1] = 0;

        // Power-on reset.
        cycle(0, 1'b1, 1'b0, 1'b0, 16'h0);
        cycle(0, 1'b1, 1'b0, 1'b0, 16'h0);

        // A: basic stream 1.0 .. 12.0, valid held high.
        seen_valid[0] = 0;
        for (int n = 1; n <= 12; n++) begin
            cycle(0, 1'b0, 1'b1, 1'b0, to_fp16(n));
            if (n == 2) begin
                check("a first win[0]", 32'(win_a[0][0]), 32'h3C00);
                check("a first win[1]", 32'(win_a[0][1]), 32'h4000);
                check("a first col",    32'(col_a),       32'd1);
                check("a first row",    32'(row_a),       32'd0);
            end
        end
        check("a basic valid count", 32'(seen_valid[0]), 32'd9);

        // A: gapped stream 1010..., same pixels.
        seen_valid[0] = 0;
        for (int n = 1; n <= 12; n++) begin
            cycle(0, 1'b0, 1'b1, 1'b0, to_fp16(n));
            cycle(0, 1'b0, 1'b0, 1'b0, 16'($urandom));
        end
        check("a gapped valid count", 32'(seen_valid[1 - 1]), 32'd9);

        // B: 3x3 over 5x4, pixel = 16*r + c.
        seen_valid[1] = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++) begin
                cycle(1, 1'b0, 1'b1, 1'b0, to_fp16(16 * r + c));
                if (r == 2 && c == 2) begin
                    check("b first win[0][0]", 32'(win_b[0][0]), 32'h0000);
                    check("b first win[0][1]", 32'(win_b[0][1]), 32'h3C00);
                    check("b first win[0][2]", 32'(win_b[0][2]), 32'h4000);
                    check("b first win[2][0]", 32'(win_b[2][0]), 32'h5000);
                    check("b first win[2][1]", 32'(win_b[2][1]), 32'h5020);
                    check("b first win[2][2]", 32'(win_b[2][2]), 32'h5040);
                end
            end
        check("b frame valid count", 32'(seen_valid[1]), 32'd6);

        // B: back-to-back second frame with random data.
        seen_valid[1] = 0;
        for (int n = 0; n < 20; n++) begin
            cycle(1, 1'b0, 1'b1, 1'b0, 16'($urandom));
            if (n == 9) check("b frame2 rows0-1 valid count", 32'(seen_valid[1]), 32'd0);
        end
        check("b frame2 valid count", 32'(seen_valid[1]), 32'd6);

        // B: random gaps up to count (3,1), then sof_i resynchronises.
        acc = 0;
        while (acc < 8) begin
            if ($urandom_range(0, 3) != 0) begin
                cycle(1, 1'b0, 1'b1, 1'b0, 16'($urandom));
                acc++;
            end else begin
                cycle(1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
            end
        end
        cycle(1, 1'b0, 1'b1, 1'b1, 16'($urandom));
        check("b sof col", 32'(col_b), 32'd0);
        check("b sof row", 32'(row_b), 32'd0);
        acc = 0;
        seen_valid[1] = 0;
        while (acc < 19) begin
            if ($urandom_range(0, 3) != 0) begin
                cycle(1, 1'b0, 1'b1, 1'b0, 16'($urandom));
                acc++;
            end else begin
                cycle(1, 1'b0, 1'b0, 1'b0, 16'($urandom));
            end
        end
        check("b post-sof valid count", 32'(seen_valid[1]), 32'd6);

        // B: reset mid-frame at (2,2), with valid_i and sof_i also active.
        for (int n = 0; n < 12; n++) cycle(1, 1'b0, 1'b1, 1'b0, 16'($urandom));
        cycle(1, 1'b1, 1'b1, 1'b1, 16'($urandom));
        seen_valid[1] = 0;
        for (int n = 0; n < 20; n++) cycle(1, 1'b0, 1'b1, 1'b0, 16'($urandom));
        check("b post-reset valid count", 32'(seen_valid[1]), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
